csa1: RTL and testbench
=======================

// Module: csa1
// PURPOSE
//   Pipelined three-operand adder: S = A + B + C (mod 2^WIDTH).
//   Stage 1 is a bitwise carry-save (3:2) compressor giving sum/carry vectors.
//   Stage 2 is a carry-propagate adder that resolves them into one result.
//   Used wherever three wide operands are summed in one pass (accumulate, checksum, MAC tail).
// PARAMETERS
//   WIDTH   64   operand and result width in bits; must be >= 2
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst       in   1      synchronous, active-high reset
//   in_valid  in   1      A/B/C are valid this cycle
//   A         in   WIDTH  operand 0
//   B         in   WIDTH  operand 1
//   C         in   WIDTH  operand 2
//   out_valid out  1      S (and COUT) hold a valid result
//   S         out  WIDTH  registered sum, low WIDTH bits of A+B+C
//   COUT      out  2      only with CSA1_COUT_EN; bits WIDTH+1:WIDTH of the true sum
// BEHAVIOUR
//   - Reset, rst=1 sampled at the clock edge: all pipeline registers clear.
//     S=0, out_valid=0 and COUT=0 from the next edge on.
//     rst has priority over in_valid.
//   - Stage 1, registered on every edge:
//     ps[i] = A[i]^B[i]^C[i]
//     pc[i+1] = maj(A[i],B[i],C[i]); pc[0] = 0
//     The pc[WIDTH] bit (carry out of the MSB column) is kept in a separate register.
//     v1 <= in_valid.
//   - Stage 2, registered: S <= ps + pc[WIDTH-1:0], then out_valid <= v1.
//   - Latency is exactly 2 cycles from the in_valid edge to the out_valid edge.
//     Throughput is 1 operation per cycle; no stall and no backpressure.
//   - Operands are sampled only when in_valid=1.
//     With in_valid=0, out_valid drops 2 cycles later.
//     S holds its last valid value; the pipeline data registers do not update.
//   - Arithmetic is unsigned modulo 2^WIDTH. Overflow is silently truncated in S.
//     All-ones on every operand is legal.
//   - Reset asserted mid-operation: any in-flight results are discarded.
//     There is no partial output.
//     The first valid output after reset release comes 2 cycles after the first in_valid.
//   - No combinational path from inputs to outputs.
// CONFIGURATION
//   CSA1_COUT_EN defined:
//     - COUT is present.
//     - COUT = {carry-out of stage 2 add, plus the registered pc[WIDTH]} as a 2-bit sum.
//     - It equals (A+B+C) >> WIDTH, range 0..2.
//     - It is registered together with S and reset to 0.
//   CSA1_COUT_EN undefined:
//     - The COUT port is absent.
//     - The carry logic above WIDTH is removed.
//     - S and out_valid are unaffected.
// TESTING
//   1. rst=1 for 2 cycles -> S=0, out_valid=0 (COUT=0).
//   2. A=B=0xAAAA_AAAA_AAAA_AAAA, C=0, in_valid=1 for 1 cycle:
//      2 cycles later S=0x5555_5555_5555_5554, out_valid=1 for 1 cycle, COUT=1.
//   3. A=B=C=0xFFFF_FFFF_FFFF_FFFF -> S=0xFFFF_FFFF_FFFF_FFFD, COUT=2.
//   4. Back-to-back in_valid with (1,2,3), (0,0,0), (0x8000_0000_0000_0000,same,0):
//      consecutive results S=6, S=0, S=0 with COUT=1; out_valid high 3 cycles.
//   5. Issue A=B=C=1 then assert rst the next cycle -> no out_valid pulse; S=0.
//   6. 10k random operand triples, random in_valid gaps:
//      S equals a (WIDTH+2)-bit reference sum truncated to WIDTH bits; COUT equals the upper bits.

Source files
------------

// File: rtl/csa1.sv
// Two-stage pipelined three-operand adder: 3:2 carry-save compressor, then a carry-propagate add.
// Define CSA1_COUT_EN to add the 2-bit COUT port carrying bits WIDTH+1:WIDTH of the true sum.
module csa1 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             out_valid,
    output logic [WIDTH-1:0] S
`ifdef CSA1_COUT_EN
    ,
    output logic [1:0]       COUT
`endif
);

    // Stage 1 combinational compressor outputs
    logic [WIDTH-1:0] ps_next;
    logic [WIDTH-1:0] pc_next;

    // Stage 1 registers
    logic [WIDTH-1:0] ps_reg;
    logic [WIDTH-1:0] pc_reg;
    logic             v1_reg;

    // Stage 2 registers
    logic [WIDTH-1:0] s_reg;
    logic             out_valid_reg;

    assign pc_next[0] = 1'b0;

    // Per-column full adder; the carry of column gi lands in column gi+1.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
        assign ps_next[gi] = A[gi] ^ B[gi] ^ C[gi];
        if (gi < WIDTH - 1) begin : g_carry
            assign pc_next[gi+1] = (A[gi] & B[gi]) | (A[gi] & C[gi]) | (B[gi] & C[gi]);
        end
    end

`ifdef CSA1_COUT_EN
    logic       pc_top_next;
    logic       pc_top_reg;
    logic [WIDTH:0] add_full;
    logic [1:0] cout_next;
    logic [1:0] cout_reg;

    assign pc_top_next = (A[WIDTH-1] & B[WIDTH-1]) | (A[WIDTH-1] & C[WIDTH-1])
                       | (B[WIDTH-1] & C[WIDTH-1]);
    assign add_full    = {1'b0, ps_reg} + {1'b0, pc_reg};
    // Upper two bits of the true sum: stage-2 carry plus the MSB column carry.
    assign cout_next   = {1'b0, add_full[WIDTH]} + {1'b0, pc_top_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_top_reg <= 1'b0;
            cout_reg   <= 2'd0;
        end else begin
            if (in_valid) begin
                pc_top_reg <= pc_top_next;
            end
            if (v1_reg) begin
                cout_reg <= cout_next;
            end
        end
    end

    assign COUT = cout_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_reg        <= '0;
            pc_reg        <= '0;
            v1_reg        <= 1'b0;
            s_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            v1_reg        <= in_valid;
            out_valid_reg <= v1_reg;
            // Data registers only move with valid data so S holds its last result.
            if (in_valid) begin
                ps_reg <= ps_next;
                pc_reg <= pc_next;
            end
            if (v1_reg) begin
                s_reg <= ps_reg + pc_reg;
            end
        end
    end

    assign S         = s_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_csa1.sv
// Directed and random checks of the csa1 three-operand adder pipeline.
module tb_csa1;
    localparam int WIDTH = 64;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] c_in;
    logic             out_valid;
    logic [WIDTH-1:0] s_out;
`ifdef CSA1_COUT_EN
    logic [1:0]       cout_out;
`endif

    int checks = 0;
    int errors = 0;

    // Reference pipeline model: true (WIDTH+2)-bit sums
    logic             m1_v;
    logic [WIDTH+1:0] m1_sum;
    logic             m2_v;
    logic [WIDTH+1:0] m2_sum;

    csa1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .C         (c_in),
        .out_valid (out_valid),
        .S         (s_out)
`ifdef CSA1_COUT_EN
        ,
        .COUT      (cout_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH+1:0] got, input logic [WIDTH+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
        rst      = r;
        in_valid = iv;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        @(posedge clk);
        #1;
        if (r) begin
            m1_v   = 1'b0;
            m1_sum = '0;
            m2_v   = 1'b0;
            m2_sum = '0;
        end else begin
            m2_v = m1_v;
            if (m1_v) m2_sum = m1_sum;
            m1_v = iv;
            if (iv) m1_sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
        end
        check("model_ov", {{(WIDTH+1){1'b0}}, out_valid}, {{(WIDTH+1){1'b0}}, m2_v});
        check("model_s", {2'b00, s_out}, {2'b00, m2_sum[WIDTH-1:0]});
`ifdef CSA1_COUT_EN
        check("model_cout", {{WIDTH{1'b0}}, cout_out}, {{WIDTH{1'b0}}, m2_sum[WIDTH+1:WIDTH]});
`endif
        $display("step rst=%0d iv=%0d a=%h b=%h c=%h -> ov=%0d s=%h",
                 r, iv, a, b, c, out_valid, s_out);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [WIDTH-1:0] s,
                           input logic [1:0] co);
        check({tag, "_ov"}, {{(WIDTH+1){1'b0}}, out_valid}, {{(WIDTH+1){1'b0}}, ov});
        check({tag, "_s"}, {2'b00, s_out}, {2'b00, s});
`ifdef CSA1_COUT_EN
        check({tag, "_cout"}, {{WIDTH{1'b0}}, cout_out}, {{WIDTH{1'b0}}, co});
`else
        if (co > 2'd2) $display("unexpected cout constant %0d", co);
`endif
    endtask

    localparam logic [WIDTH-1:0] AA   = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [WIDTH-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [WIDTH-1:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [WIDTH-1:0] Z    = 64'h0;

    initial begin
        m1_v = 1'b0; m1_sum = '0; m2_v = 1'b0; m2_sum = '0;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; c_in = '0;

        // Reset
        step(1'b1, 1'b0, Z, Z, Z);
        step(1'b1, 1'b0, Z, Z, Z);
        chk_out("rst", 1'b0, Z, 2'd0);

        // Alternating bits: single pulse, two-cycle latency
        step(1'b0, 1'b1, AA, AA, Z);
        chk_out("aa_lat1", 1'b0, Z, 2'd0);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("aa", 1'b1, 64'h5555_5555_5555_5554, 2'd1);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("aa_hold", 1'b0, 64'h5555_5555_5555_5554, 2'd1);

        // All ones on every operand
        step(1'b0, 1'b1, ONES, ONES, ONES);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("ones", 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 2'd2);
        step(1'b0, 1'b0, Z, Z, Z);

        // Back-to-back operations
        step(1'b0, 1'b1, 64'd1, 64'd2, 64'd3);
        step(1'b0, 1'b1, Z, Z, Z);
        chk_out("b2b0", 1'b1, 64'd6, 2'd0);
        step(1'b0, 1'b1, MSB, MSB, Z);
        chk_out("b2b1", 1'b1, Z, 2'd0);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("b2b2", 1'b1, Z, 2'd1);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("b2b_end", 1'b0, Z, 2'd1);

        // Reset right behind an in-flight operation discards it
        step(1'b0, 1'b1, 64'd1, 64'd1, 64'd1);
        step(1'b1, 1'b0, Z, Z, Z);
        chk_out("abort_rst", 1'b0, Z, 2'd0);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("abort1", 1'b0, Z, 2'd0);
        step(1'b0, 1'b0, Z, Z, Z);
        chk_out("abort2", 1'b0, Z, 2'd0);

        // Random operands with random gaps and rare resets
        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH-1:0] ra, rb, rc;
            logic             riv, rr;
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rc  = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) ra = ONES;
            if ($urandom_range(0, 15) == 0) rb = ONES;
            if ($urandom_range(0, 15) == 0) rc = ONES;
            riv = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 199) == 0);
            step(rr, riv, ra, rb, rc);
        end
        step(1'b0, 1'b0, Z, Z, Z);
        step(1'b0, 1'b0, Z, Z, Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
